// File: rtl/alu_issue_unit_if.sv
// Command/result handshake bundle for alu_issue_unit.
// slave is the issue unit's view; master is the producer/consumer view.
interface alu_issue_unit_if #(
  parameter int WIDTH  = 8,
  parameter int FUNC_W = 3,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // command side
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic [FUNC_W-1:0] in_func;

  // result side
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_result;
  logic              out_cout;
  logic              out_zero;
  logic [FUNC_W-1:0] out_func;

  // FIFO occupancy (excludes the output register)
  logic [CW-1:0]     count;

  modport slave (
    input  in_valid, in_a, in_b, in_func, out_ready,
    output in_ready, out_valid, out_result, out_cout, out_zero, out_func, count
  );

  modport master (
    output in_valid, in_a, in_b, in_func, out_ready,
    input  in_ready, out_valid, out_result, out_cout, out_zero, out_func, count
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Issue stage in front of the combinational alu: a small command FIFO whose
// head drives the alu, and an output register that captures the alu result
// with carry/borrow and a zero flag.
module alu_issue_unit #(
  parameter int WIDTH  = 8,
  parameter int FUNC_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_unit_if.slave   bus,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_cout
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;

  out_state_t        state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  out_result_q, out_result_d;
  logic              out_cout_q, out_cout_d;
  logic              out_zero_q, out_zero_d;
  logic [FUNC_W-1:0] out_func_q, out_func_d;

  logic [WIDTH-1:0]  a_mem_q [DEPTH];
  logic [WIDTH-1:0]  a_mem_d [DEPTH];
  logic [WIDTH-1:0]  b_mem_q [DEPTH];
  logic [WIDTH-1:0]  b_mem_d [DEPTH];
  logic [FUNC_W-1:0] f_mem_q [DEPTH];
  logic [FUNC_W-1:0] f_mem_d [DEPTH];

  logic push;
  logic pop;

  // in_ready depends on registered occupancy only, so a full FIFO never
  // accepts even when the output side drains in the same cycle.
  assign bus.in_ready = (count_q < CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;

  // Head entry feeds the alu continuously.
  assign alu_a    = a_mem_q[rd_ptr_q];
  assign alu_b    = b_mem_q[rd_ptr_q];
  assign alu_func = f_mem_q[rd_ptr_q];

  assign bus.out_valid  = (state_q == OUT_FULL);
  assign bus.out_result = out_result_q;
  assign bus.out_cout   = out_cout_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.out_func   = out_func_q;
  assign bus.count      = count_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Entry write: load the incoming command when the write pointer selects it.
    always_comb begin
      a_mem_d[gi] = a_mem_q[gi];
      b_mem_d[gi] = b_mem_q[gi];
      f_mem_d[gi] = f_mem_q[gi];
      if (push && (wr_ptr_q == PW'(gi))) begin
        a_mem_d[gi] = bus.in_a;
        b_mem_d[gi] = bus.in_b;
        f_mem_d[gi] = bus.in_func;
      end
    end

    // Entry storage; cleared on reset so the alu sees zeros before any push.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_mem_q[gi] <= '0;
        b_mem_q[gi] <= '0;
        f_mem_q[gi] <= '0;
      end else begin
        a_mem_q[gi] <= a_mem_d[gi];
        b_mem_q[gi] <= b_mem_d[gi];
        f_mem_q[gi] <= f_mem_d[gi];
      end
    end
  end

  // State register: FSM state, FIFO pointers/occupancy and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OUT_EMPTY;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_result_q <= '0;
      out_cout_q   <= 1'b0;
      out_zero_q   <= 1'b0;
      out_func_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_result_q <= out_result_d;
      out_cout_q   <= out_cout_d;
      out_zero_q   <= out_zero_d;
      out_func_q   <= out_func_d;
    end
  end

  // Next-state logic: fill when a command is waiting, empty when the
  // consumer takes the last result and nothing is queued behind it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (count_q != '0) state_d = OUT_FULL;
      OUT_FULL:  if (bus.out_ready && (count_q == '0)) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  // Output logic: pop the head into the output register whenever it is free
  // or being consumed this cycle; update pointers and occupancy.
  always_comb begin
    pop          = (count_q != '0) && ((state_q == OUT_EMPTY) || bus.out_ready);
    out_result_d = out_result_q;
    out_cout_d   = out_cout_q;
    out_zero_d   = out_zero_q;
    out_func_d   = out_func_q;
    if (pop) begin
      out_result_d = alu_result;
      // Cout is only meaningful for add (0) and subtract (1).
      out_cout_d   = (alu_func < FUNC_W'(2)) ? alu_cout : 1'b0;
      out_zero_d   = (alu_result == '0);
      out_func_d   = alu_func;
    end
    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end
endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Front-end stage directly upstream of the 8-bit combinational alu.
- Buffers operation commands {a, b, func} in a small FIFO and presents the head entry to the alu from registered storage.
- Captures alu result and carry/borrow into an output register, adding a zero flag.
- Valid/ready handshakes on both sides decouple command producers from result consumers.

Parameters:
- WIDTH, 8, operand/result width (matches alu).
- FUNC_W, 3, function-code width (matches alu).
- DEPTH, 4, command FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command present.
- in_ready  output  1  FIFO can accept a command.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- in_func  input  FUNC_W  function code.
- alu_a  output  WIDTH  to alu a.
- alu_b  output  WIDTH  to alu b.
- alu_func  output  FUNC_W  to alu func.
- alu_result  input  WIDTH  from alu result.
- alu_cout  input  1  from alu Cout (carry for func 0, borrow for func 1).
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  captured result.
- out_cout  output  1  captured carry/borrow; 0 for func 2..7.
- out_zero  output  1  1 when out_result == 0.
- out_func  output  FUNC_W  func of the captured result.
- count  output  $clog2(DEPTH+1)  FIFO occupancy, excluding the output register.

Behaviour:
- Reset (async assert, sync-to-clk deassert by the system):
  - FIFO pointers and count = 0; FIFO contents are don't-care.
  - out_valid, out_result, out_cout, out_zero, out_func = 0.
  - in_ready = 1 from the first cycle after reset.
- Push: in_valid && in_ready at a rising edge writes {in_a, in_b, in_func} at the write pointer, which then increments mod DEPTH.
- in_ready = (count < DEPTH); registered-state only, with no combinational path from out_ready.
  - When full, a same-cycle pop does not enable a push.
- alu_a/alu_b/alu_func are driven from the FIFO head entry at all times.
  - When the FIFO is empty they hold the last head location's contents (0 after reset).
- Output FSM, two states:
  - OUT_EMPTY (out_valid=0):
    - If count>0: at the edge, capture alu_result, alu_cout (masked to 0 unless head func is 0 or 1), zero flag and head func into the output register; pop the FIFO; go to OUT_FULL.
    - Otherwise stay in OUT_EMPTY.
  - OUT_FULL (out_valid=1):
    - If out_ready && count>0: capture the next head and pop; stay in OUT_FULL. This gives back-to-back results, one per cycle.
    - If out_ready && count==0: go to OUT_EMPTY.
    - If !out_ready: hold all out_* stable; no pop.
- Latency: a command pushed into an empty unit at edge N gives out_valid=1 with its result after edge N+1. Throughput is 1 command/cycle.
- Simultaneous push and pop:
  - count is unchanged; both pointers advance.
  - If count==0, a push in the same cycle is not popped that cycle; it issues next cycle.
- Ordering: results leave strictly in command order.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
- out_zero is computed from alu_result at capture, not recomputed later.
- Reset mid-operation:
  - Buffered commands and any pending result are discarded.
  - out_valid drops asynchronously on rst_n assertion.
- Protocol: in_* must stay stable while in_valid && !in_ready.

Test Plan:
- Basic op: push a=75, b=61, func=0, out_ready=1 -> one cycle later out_valid=1, out_result=136, out_cout=0, out_zero=0, out_func=0.
- Carry/borrow/zero stream: push (200,100,0), (61,75,1), (5,5,1) back-to-back -> three consecutive cycles give:
  - 44, cout=1
  - 242, cout=1
  - 0, cout=0, zero=1
- Cout mask: push (255,1,2) -> out_cout=0 regardless of alu_cout.
- Backpressure/full: out_ready=0, push 6 commands -> 5 accepted (1 in output register, count=4); in_ready=0 on the 6th; out_* stable. Raise out_ready -> the 5 results drain in order on consecutive cycles; in_ready=1 after the first drain edge.
- Wrap-around: push/pop 10 commands with alternating out_ready -> all results in order, count never exceeds 4, no loss or duplication across pointer wrap.
- Mid-operation reset: with count=3 and out_valid=1, pulse rst_n low between edges -> out_valid=0 and count=0 immediately; after release, in_ready=1 and no stale result appears.
